// File: rtl/mdu_e.sv
// Multi-cycle multiply/divide unit for the E stage.
// Holds the architectural HI/LO registers. mult/multu/div/divu latch their operands at launch,
// hold busy for a fixed number of cycles and then commit HI/LO with a one-cycle done pulse.
// mthi/mtlo commit SrcA in a single cycle whenever the unit is idle.
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset_n  - asynchronous active-low reset
//   start    - launch request, only honoured with MDUop 1..4 while idle
//   MDUop    - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   SrcA     - operand A / dividend / mthi-mtlo source
//   SrcB     - operand B / divisor
//   busy     - operation in flight
//   done     - one-cycle pulse, HI/LO just updated by mult/div
//   HI, LO   - architectural HI/LO registers
module mdu_e #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  MDUop,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6,
        OpRsvd  = 3'd7
    } mdu_op_e;

    localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
    localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

    mdu_op_e     op_q, op_d, op_in;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;

    logic [31:0] res_hi, res_lo;
    logic [63:0] ext_a, ext_b, prod;
    logic        is_signed, a_neg, b_neg;
    logic [31:0] abs_a, abs_b, divisor, uq, ur;

    assign op_in = mdu_op_e'(MDUop);

    // Result datapath, driven only by the latched operands so later SrcA/SrcB changes are moot.
    always_comb begin
        is_signed = (op_q == OpMult) || (op_q == OpDiv);
        // Extending to 64 bits and keeping the low 64 bits of the product gives the exact
        // signed or unsigned 64-bit result from a single multiplier.
        ext_a = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = ext_a * ext_b;

        // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        a_neg   = is_signed && a_q[31];
        b_neg   = is_signed && b_q[31];
        abs_a   = a_neg ? (32'd0 - a_q) : a_q;
        abs_b   = b_neg ? (32'd0 - b_q) : b_q;
        divisor = (b_q == 32'd0) ? 32'd1 : abs_b;
        uq      = abs_a / divisor;
        ur      = abs_a % divisor;

        res_hi = 32'd0;
        res_lo = 32'd0;
        unique case (op_q)
            OpMult, OpMultu: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OpDiv, OpDivu: begin
                if (b_q == 32'd0) begin
                    res_hi = a_q;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_lo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
                    res_hi = a_neg ? (32'd0 - ur) : ur;
                end
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    always_comb begin
        op_d   = op_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (cnt_q != 4'd0) begin
            // Busy: every request is ignored until the counter drains.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d   = res_hi;
                lo_d   = res_lo;
                done_d = 1'b1;
            end
        end else if (start && (op_in == OpMult || op_in == OpMultu ||
                               op_in == OpDiv  || op_in == OpDivu)) begin
            op_d  = op_in;
            a_d   = SrcA;
            b_d   = SrcB;
            cnt_d = (op_in == OpMult || op_in == OpMultu) ? MultCnt : DivCnt;
        end else if (op_in == OpMthi) begin
            hi_d = SrcA;
        end else if (op_in == OpMtlo) begin
            lo_d = SrcA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= OpNone;
            cnt_q  <= 4'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign busy = (cnt_q != 4'd0);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
